addsub_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational n-bit adder/subtractor.
- Splits a WIDTH-bit add/subtract into STAGES chunks, with the carry registered between chunks.
- Adds a valid/ready handshake with backpressure, signed/unsigned saturation, and result flags.
- Sits between operand producers and consumers that need high clock rates on wide datapaths.

---
 rtl/addsub_pipe.sv | 148 ++++++++++++++
 tb/tb_addsub_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: STAGES chunks with a registered carry chain,
// valid/ready flow control with global stall, optional saturation and result flags.
module addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             add_n,
  input  logic             sat_en,
  input  logic             signed_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);
  localparam int CW = WIDTH / STAGES;

  logic adv;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  function automatic logic detect_ovf(input logic is_signed, input logic is_sub,
                                      input logic carry_msb_in, input logic carry_out);
    logic o;
    if (is_signed) o = carry_msb_in ^ carry_out;
    else           o = is_sub ? ~carry_out : carry_out;
    return o;
  endfunction

  // Signed limit direction comes from the inverted MSB of the wrapped raw result.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw, input logic do_sat,
                                                input logic is_signed, input logic is_sub);
    logic [WIDTH-1:0] r;
    r = raw;
    if (do_sat) begin
      if (is_signed) begin
        r            = {WIDTH{raw[WIDTH-1]}};
        r[WIDTH-1]   = ~raw[WIDTH-1];
      end else begin
        r            = {WIDTH{~is_sub}};
      end
    end
    return r;
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int XW = WIDTH - k * CW;

    logic [XW-1:0]         x_in;
    logic [XW-1:0]         yi_in;
    logic [(k+1)*CW-1:0]   sum_nxt;
    logic                  carry_in;
    logic                  sub_in;
    logic                  sat_in;
    logic                  sgn_in;
    logic                  vld_in;
    logic [CW:0]           part;

    if (k == 0) begin : g_src
      assign x_in     = x;
      assign yi_in    = y ^ {WIDTH{add_n}};
      assign carry_in = add_n;
      assign sub_in   = add_n;
      assign sat_in   = sat_en;
      assign sgn_in   = signed_en;
      assign vld_in   = in_valid;
      assign sum_nxt  = part[CW-1:0];
    end else begin : g_src
      assign x_in     = g_stage[k-1].g_reg.x_p;
      assign yi_in    = g_stage[k-1].g_reg.yi_p;
      assign carry_in = g_stage[k-1].g_reg.cy_p;
      assign sub_in   = g_stage[k-1].g_reg.sub_p;
      assign sat_in   = g_stage[k-1].g_reg.sat_p;
      assign sgn_in   = g_stage[k-1].g_reg.sgn_p;
      assign vld_in   = g_stage[k-1].g_reg.vld_p;
      assign sum_nxt  = {part[CW-1:0], g_stage[k-1].g_reg.sum_p};
    end

    assign part = {1'b0, x_in[CW-1:0]} + {1'b0, yi_in[CW-1:0]} + {{CW{1'b0}}, carry_in};

    if (k < STAGES - 1) begin : g_reg
      // Stage k boundary: finished low chunks, carry, and the unconsumed upper operand bits.
      logic [XW-CW-1:0]    x_p;
      logic [XW-CW-1:0]    yi_p;
      logic [(k+1)*CW-1:0] sum_p;
      logic                cy_p;
      logic                sub_p;
      logic                sat_p;
      logic                sgn_p;
      logic                vld_p;

      always_ff @(posedge clk) begin
        if (rst)      vld_p <= 1'b0;
        else if (adv) vld_p <= vld_in;
      end

      always_ff @(posedge clk) begin
        if (adv) begin
          x_p   <= x_in[XW-1:CW];
          yi_p  <= yi_in[XW-1:CW];
          sum_p <= sum_nxt;
          cy_p  <= part[CW];
          sub_p <= sub_in;
          sat_p <= sat_in;
          sgn_p <= sgn_in;
        end
      end
    end else begin : g_out
      logic             carry_msb;
      logic             ovf_nxt;
      logic [WIDTH-1:0] res_nxt;

      // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
      assign carry_msb = part[CW-1] ^ x_in[CW-1] ^ yi_in[CW-1];
      assign ovf_nxt   = detect_ovf(sgn_in, sub_in, carry_msb, part[CW]);
      assign res_nxt   = saturate(sum_nxt, sat_in & ovf_nxt, sgn_in, sub_in);

      // Output boundary: bubbles clear the result and flags.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid <= 1'b0;
          result    <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
          neg       <= 1'b0;
        end else if (adv) begin
          out_valid <= vld_in;
          result    <= vld_in ? res_nxt : '0;
          cout      <= vld_in & part[CW];
          ovf       <= vld_in & ovf_nxt;
          zero      <= vld_in & (res_nxt == '0);
          neg       <= vld_in & res_nxt[WIDTH-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=8, STAGES=2) with a queue scoreboard.
module tb_addsub_pipe;
  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             add_n;
  logic             sat_en;
  logic             signed_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .add_n(add_n), .sat_en(sat_en), .signed_en(signed_en),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  // {result, cout, ovf, zero, neg}
  typedef logic [WIDTH+3:0] obs_t;
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       sat;
    logic       sgn;
    obs_t       exp;
  } vec_t;

  obs_t dut_obs;
  assign dut_obs = {result, cout, ovf, zero, neg};

  obs_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic acc;
  logic took;

  function automatic obs_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic sub, input logic sat, input logic sgn);
    int         ua, ub, sa, sbv, ru, rs;
    logic [7:0] res;
    logic       c, o;
    ua = a; ub = b;
    sa = $signed(a); sbv = $signed(b);
    if (sub) begin
      ru = ua - ub; rs = sa - sbv; c = (ua >= ub);
    end else begin
      ru = ua + ub; rs = sa + sbv; c = (ru > 255);
    end
    res = ru[7:0];
    if (sgn) o = (rs > 127) || (rs < -128);
    else     o = sub ? ~c : c;
    if (sat && o) begin
      if (sgn) res = (rs > 127) ? 8'h7F : 8'h80;
      else     res = sub ? 8'h00 : 8'hFF;
    end
    return {res, c, o, (res == 8'h00), res[7]};
  endfunction

  // Drive one cycle of inputs at the falling edge; report the handshakes of the coming rising edge.
  task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic s_sub, input logic s_sat,
                      input logic s_sgn, input logic ordy);
    @(negedge clk);
    rst = r; in_valid = v; x = a; y = b;
    add_n = s_sub; sat_en = s_sat; signed_en = s_sgn; out_ready = ordy;
    #1;
    acc  = v & in_ready & ~r;
    took = out_valid & ordy & ~r;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if (dut_obs !== '0) $display("FAIL reset_outputs: got %h want 000", dut_obs);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_directed();
    vec_t tbl [10] = '{
      '{8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, {8'h00, 4'b1110}},
      '{8'h7F, 8'h01, 1'b0, 1'b1, 1'b1, {8'h7F, 4'b0100}},
      '{8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, {8'h80, 4'b0101}},
      '{8'h05, 8'h07, 1'b1, 1'b0, 1'b0, {8'hFE, 4'b0101}},
      '{8'h05, 8'h07, 1'b1, 1'b1, 1'b0, {8'h00, 4'b0110}},
      '{8'h80, 8'hFF, 1'b0, 1'b1, 1'b1, {8'h80, 4'b1101}},
      '{8'h80, 8'h01, 1'b1, 1'b1, 1'b1, {8'h80, 4'b1101}},
      '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, {8'hFF, 4'b1101}},
      '{8'h07, 8'h05, 1'b1, 1'b0, 1'b0, {8'h02, 4'b1000}},
      '{8'h05, 8'h05, 1'b1, 1'b1, 1'b1, {8'h00, 4'b1010}}
    };
    int   lat;
    obs_t e;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].sat, tbl[i].sgn, 1'b1);
      n_checks++;
      if (acc !== 1'b1) $display("FAIL dir%0d_accept: got %b want 1", i, acc);
      else n_pass++;
      if (acc) sb.push_back(tbl[i].exp);
      lat = 0;
      do begin
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        lat++;
      end while (!out_valid && lat < 8);
      n_checks++;
      if (lat != STAGES) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, STAGES);
      else n_pass++;
      n_checks++;
      if (!took || sb.size() == 0) begin
        $display("FAIL dir%0d_out: no result beat (took=%b queued=%0d)", i, took, sb.size());
      end else begin
        e = sb.pop_front();
        if (dut_obs !== e) $display("FAIL dir%0d_out: got {res,c,o,z,n}=%h want %h", i, dut_obs, e);
        else n_pass++;
      end
    end
    sb.delete();
  endtask

  task automatic test_stream();
    logic [7:0] a, b;
    logic [2:0] m;
    logic       exp_v;
    int         got;
    obs_t       e;
    got = 0;
    for (int i = 0; i < 22; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      m = 3'($urandom);
      step(1'b0, i < 16, a, b, m[0], m[1], m[2], 1'b1);
      exp_v = (i >= STAGES) && (i < 16 + STAGES);
      n_checks++;
      if (out_valid !== exp_v) $display("FAIL stream_valid%0d: got %b want %b", i, out_valid, exp_v);
      else n_pass++;
      if (took) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL stream_out%0d: unexpected beat got %h want none", i, dut_obs);
        end else begin
          e = sb.pop_front();
          if (dut_obs !== e) $display("FAIL stream_out%0d: got {res,c,o,z,n}=%h want %h", i, dut_obs, e);
          else n_pass++;
        end
        got++;
      end
      if (acc) sb.push_back(model(a, b, m[0], m[1], m[2]));
    end
    n_checks++;
    if (got != 16 || sb.size() != 0) $display("FAIL stream_count: got %0d left %0d want 16 left 0", got, sb.size());
    else n_pass++;
    sb.delete();
  endtask

  task automatic test_backpressure();
    logic [7:0] ba [4] = '{8'hC8, 8'h10, 8'h7F, 8'h00};
    logic [7:0] bb [4] = '{8'h50, 8'h20, 8'h7F, 8'h00};
    logic [2:0] bm [4] = '{3'b010, 3'b101, 3'b110, 3'b000};
    int   nxt, got, idx;
    logic ordy;
    obs_t e;
    nxt = 0; got = 0;
    for (int i = 0; i < 20 && got < 3; i++) begin
      ordy = (i >= 6);
      idx  = (nxt < 3) ? nxt : 3;
      step(1'b0, nxt < 3, ba[idx], bb[idx], bm[idx][0], bm[idx][1], bm[idx][2], ordy);
      if (i >= STAGES && i < 6) begin
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0)
          $display("FAIL bp_stall%0d: got valid=%b in_ready=%b want valid=1 in_ready=0", i, out_valid, in_ready);
        else n_pass++;
        n_checks++;
        if (sb.size() == 0) $display("FAIL bp_hold%0d: nothing queued, got %h", i, dut_obs);
        else if (dut_obs !== sb[0]) $display("FAIL bp_hold%0d: got %h want %h", i, dut_obs, sb[0]);
        else n_pass++;
      end
      if (took) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL bp_out%0d: unexpected beat got %h want none", got, dut_obs);
        end else begin
          e = sb.pop_front();
          if (dut_obs !== e) $display("FAIL bp_out%0d: got {res,c,o,z,n}=%h want %h", got, dut_obs, e);
          else n_pass++;
        end
        got++;
      end
      if (acc) begin
        sb.push_back(model(ba[idx], bb[idx], bm[idx][0], bm[idx][1], bm[idx][2]));
        nxt++;
      end
    end
    n_checks++;
    if (got != 3 || nxt != 3 || sb.size() != 0)
      $display("FAIL bp_count: got delivered=%0d accepted=%0d left=%0d want 3 3 0", got, nxt, sb.size());
    else n_pass++;
    sb.delete();
  endtask

  task automatic test_reset_flush();
    step(1'b0, 1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h33, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if (dut_obs !== '0) $display("FAIL flush_outputs: got %h want 000", dut_obs);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL flush_stale%0d: got valid=%b want 0", i, out_valid);
      else n_pass++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0;
    add_n = 1'b0; sat_en = 1'b0; signed_en = 1'b0; out_ready = 1'b1;
    test_reset();
    test_directed();
    test_stream();
    test_backpressure();
    test_reset_flush();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
